rv32i_muldiv_iter: RTL and testbench

- Iterative RV32M multiply/divide unit, directly downstream of the register bank.
- Consumes the rs1/rs2 operand words and the 4-bit destination index.
- Returns a 32-bit result with a write-enable pulse for the bank's din/wen/rd_16 write port.
- Single shared 64-bit shift datapath, radix-2, one bit per clock; core stalls on busy.

---
 rtl/rv32i_muldiv_iter_if.sv | 24 ++
 rtl/rv32i_muldiv_iter.sv | 169 ++++++++++++++++
 tb/tb_rv32i_muldiv_iter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/rv32i_muldiv_iter_if.sv
// Request/response bundle between the register bank side and the iterative
// RV32M multiply/divide unit.
interface rv32i_muldiv_iter_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1_d;
  logic [31:0] rs2_d;
  logic [3:0]  rd_in;
  logic        busy;
  logic        done;
  logic        wen_out;
  logic [3:0]  rd_out;
  logic [31:0] result;

  modport master (
    output start, op, rs1_d, rs2_d, rd_in,
    input  busy, done, wen_out, rd_out, result
  );

  modport slave (
    input  start, op, rs1_d, rs2_d, rd_in,
    output busy, done, wen_out, rd_out, result
  );
endinterface

// File: rtl/rv32i_muldiv_iter.sv
// Iterative RV32M multiply/divide: one radix-2 step per clock on a shared
// 64-bit {hi,lo} shift register, sign fix-up in a separate cycle.
module rv32i_muldiv_iter #(
  parameter int unsigned XLEN         = 32'd32,
  parameter bit          FAST_SPECIAL = 1'b1
) (
  input logic             clk,
  input logic             rst,
  rv32i_muldiv_iter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [XLEN-1:0] ZERO_W = {XLEN{1'b0}};
  localparam logic [XLEN-1:0] ONES_W = {XLEN{1'b1}};
  localparam logic [XLEN-1:0] MIN_W  = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state_r;
  logic [2:0]      op_r;
  logic [3:0]      rd_r;
  logic [XLEN-1:0] opnd_r;
  logic [XLEN-1:0] hi_r;
  logic [XLEN-1:0] lo_r;
  logic            neg_r;
  logic            special_r;
  logic [4:0]      count_r;
  logic            busy_r;
  logic            done_r;
  logic [XLEN-1:0] result_r;

  logic            a_sgn_s, b_sgn_s, a_neg_s, b_neg_s, neg_res_s;
  logic            divz_s, ovf_s;
  logic [XLEN-1:0] mag_a_s, mag_b_s, spec_res_s;
  logic [XLEN:0]   mul_sum_s;
  logic [XLEN:0]   div_shift_s;
  logic [XLEN-1:0] div_diff_s;
  logic            div_ok_s;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0] div_raw_s, div_fix_s, fix_res_s;
  logic            fix_neg_s;

  // Operand decode at accept: signedness, magnitudes, result sign, special cases
  always_comb begin
    a_sgn_s = 1'b0;
    b_sgn_s = 1'b0;
    case (bus.op)
      3'd1:       begin a_sgn_s = 1'b1; b_sgn_s = 1'b1; end
      3'd2:       begin a_sgn_s = 1'b1; b_sgn_s = 1'b0; end
      3'd4, 3'd6: begin a_sgn_s = 1'b1; b_sgn_s = 1'b1; end
      default:    begin a_sgn_s = 1'b0; b_sgn_s = 1'b0; end
    endcase
    a_neg_s   = a_sgn_s & bus.rs1_d[XLEN-1];
    b_neg_s   = b_sgn_s & bus.rs2_d[XLEN-1];
    mag_a_s   = a_neg_s ? (~bus.rs1_d + {{(XLEN-1){1'b0}}, 1'b1}) : bus.rs1_d;
    mag_b_s   = b_neg_s ? (~bus.rs2_d + {{(XLEN-1){1'b0}}, 1'b1}) : bus.rs2_d;
    // Remainder takes the dividend's sign; everything else is the xor
    neg_res_s = (bus.op[2] & bus.op[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
    divz_s    = bus.op[2] & (bus.rs2_d == ZERO_W);
    ovf_s     = bus.op[2] & ~bus.op[0] & (bus.rs1_d == MIN_W) & (bus.rs2_d == ONES_W);
    if (divz_s) begin
      spec_res_s = bus.op[1] ? bus.rs1_d : ONES_W;
    end else begin
      spec_res_s = bus.op[1] ? ZERO_W : MIN_W;
    end
  end

  // One radix-2 step for each datapath mode
  always_comb begin
    mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {1'b0, ZERO_W});
    div_shift_s = {hi_r, lo_r[XLEN-1]};
    div_ok_s    = (div_shift_s >= {1'b0, opnd_r});
    div_diff_s  = div_shift_s[XLEN-1:0] - opnd_r;
  end

  // Sign fix-up and result select; special cases keep the raw value
  always_comb begin
    fix_neg_s = neg_r & ~special_r;
    prod_s    = fix_neg_s ? (~{hi_r, lo_r} + {{(2*XLEN-1){1'b0}}, 1'b1}) : {hi_r, lo_r};
    div_raw_s = op_r[1] ? hi_r : lo_r;
    div_fix_s = fix_neg_s ? (~div_raw_s + {{(XLEN-1){1'b0}}, 1'b1}) : div_raw_s;
    case (op_r)
      3'd0:             fix_res_s = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fix_res_s = prod_s[2*XLEN-1:XLEN];
      default:          fix_res_s = div_fix_s;
    endcase
  end

  // Control FSM with registered outputs and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      op_r      <= 3'd0;
      rd_r      <= 4'd0;
      opnd_r    <= ZERO_W;
      hi_r      <= ZERO_W;
      lo_r      <= ZERO_W;
      neg_r     <= 1'b0;
      special_r <= 1'b0;
      count_r   <= 5'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      result_r  <= ZERO_W;
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (bus.start) begin
            op_r      <= bus.op;
            rd_r      <= bus.rd_in;
            neg_r     <= neg_res_s;
            special_r <= divz_s | ovf_s;
            opnd_r    <= bus.op[2] ? mag_b_s : mag_a_s;
            lo_r      <= bus.op[2] ? mag_a_s : mag_b_s;
            hi_r      <= ZERO_W;
            count_r   <= 5'd0;
            busy_r    <= 1'b1;
            if (FAST_SPECIAL && (divz_s | ovf_s)) begin
              result_r <= spec_res_s;
              done_r   <= 1'b1;
              state_r  <= DONE;
            end else begin
              state_r  <= CALC;
            end
          end
        end
        CALC: begin
          if (op_r[2]) begin
            hi_r <= div_ok_s ? div_diff_s : div_shift_s[XLEN-1:0];
            lo_r <= {lo_r[XLEN-2:0], div_ok_s};
          end else begin
            hi_r <= mul_sum_s[XLEN:1];
            lo_r <= {mul_sum_s[0], lo_r[XLEN-1:1]};
          end
          count_r <= count_r + 5'd1;
          if (count_r == 5'd31) begin
            state_r <= FIX;
          end
        end
        FIX: begin
          result_r <= fix_res_s;
          done_r   <= 1'b1;
          state_r  <= DONE;
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.wen_out = done_r;
  assign bus.rd_out  = rd_r;
  assign bus.result  = result_r;

endmodule

// File: tb/tb_rv32i_muldiv_iter.sv
// Directed bench for the iterative RV32M unit: latency, results, pulse shape,
// back-to-back start handling and mid-op reset.
module tb_rv32i_muldiv_iter;
  localparam bit FAST = 1'b1;
  localparam int SPECIAL_LAT = FAST ? 1 : 34;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  rv32i_muldiv_iter_if bus();

  rv32i_muldiv_iter #(.FAST_SPECIAL(FAST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Issue one op, then scramble inputs; returns what was observed at done
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] rd, output int lat, output logic [31:0] res,
                       output logic [3:0] rdo, output logic wen, output logic after);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.rs1_d = a; bus.rs2_d = b; bus.rd_in = rd;
    @(negedge clk);
    bus.start = 1'b0; bus.op = ~op; bus.rs1_d = ~a; bus.rs2_d = b ^ 32'h5a5a_5a5a; bus.rd_in = ~rd;
    lat = 1;
    while (!bus.done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    res = bus.result; rdo = bus.rd_out; wen = bus.wen_out;
    @(negedge clk);
    after = bus.done | bus.wen_out;
  endtask

  task automatic test_reset;
    bus.start = 1'b0; bus.op = 3'd0; bus.rs1_d = 32'd0; bus.rs2_d = 32'd0; bus.rd_in = 4'd0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.done, bus.wen_out} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got %b want 000", {bus.busy, bus.done, bus.wen_out});
    end
    n_cmp++;
    if (bus.result !== 32'd0) begin n_err++; $display("FAIL reset_result: got %h want 0", bus.result); end
    n_cmp++;
    if (bus.rd_out !== 4'd0) begin n_err++; $display("FAIL reset_rd: got %0d want 0", bus.rd_out); end
  endtask

  task automatic test_mul;
    logic [2:0]  t_op[5]  = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd0};
    logic [31:0] t_a[5]   = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_b[5]   = '{32'd6, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_exp[5] = '{32'h0000_002A, 32'h0000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001};
    int lat; logic [31:0] res; logic [3:0] rdo; logic wen, after;
    for (int i = 0; i < 5; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], 4'(i + 5), lat, res, rdo, wen, after);
      n_cmp++;
      if (lat !== 34) begin n_err++; $display("FAIL mul_lat[%0d]: got %0d want 34", i, lat); end
      n_cmp++;
      if (res !== t_exp[i]) begin n_err++; $display("FAIL mul_res[%0d]: got %h want %h", i, res, t_exp[i]); end
      n_cmp++;
      if (rdo !== 4'(i + 5)) begin n_err++; $display("FAIL mul_rd[%0d]: got %0d want %0d", i, rdo, i + 5); end
      n_cmp++;
      if ({wen, after} !== 2'b10) begin n_err++; $display("FAIL mul_wen_pulse[%0d]: got %b want 10", i, {wen, after}); end
    end
  endtask

  task automatic test_div;
    logic [2:0]  t_op[4]  = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] t_a[4]   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    logic [31:0] t_exp[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'h0000_0001};
    int lat; logic [31:0] res; logic [3:0] rdo; logic wen, after;
    for (int i = 0; i < 4; i++) begin
      do_op(t_op[i], t_a[i], 32'd2, 4'd1, lat, res, rdo, wen, after);
      n_cmp++;
      if (lat !== 34) begin n_err++; $display("FAIL div_lat[%0d]: got %0d want 34", i, lat); end
      n_cmp++;
      if (res !== t_exp[i]) begin n_err++; $display("FAIL div_res[%0d]: got %h want %h", i, res, t_exp[i]); end
    end
  endtask

  task automatic test_special;
    logic [2:0]  t_op[4]  = '{3'd4, 3'd6, 3'd5, 3'd7};
    logic [31:0] t_a[4]   = '{32'h8000_0000, 32'h8000_0000, 32'd123, 32'd123};
    logic [31:0] t_b[4]   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] t_exp[4] = '{32'h8000_0000, 32'h0000_0000, 32'hFFFF_FFFF, 32'd123};
    int lat; logic [31:0] res; logic [3:0] rdo; logic wen, after;
    for (int i = 0; i < 4; i++) begin
      do_op(t_op[i], t_a[i], t_b[i], 4'd2, lat, res, rdo, wen, after);
      n_cmp++;
      if (lat !== SPECIAL_LAT) begin n_err++; $display("FAIL spec_lat[%0d]: got %0d want %0d", i, lat, SPECIAL_LAT); end
      n_cmp++;
      if (res !== t_exp[i]) begin n_err++; $display("FAIL spec_res[%0d]: got %h want %h", i, res, t_exp[i]); end
      n_cmp++;
      if ({wen, after} !== 2'b10) begin n_err++; $display("FAIL spec_pulse[%0d]: got %b want 10", i, {wen, after}); end
    end
  endtask

  task automatic test_back_to_back;
    int dones = 0, idle_cyc = 0, gap_k = -1, done_k1 = -1, done_k2 = -1;
    logic [31:0] r1 = 32'd0, r2 = 32'd0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd0; bus.rs1_d = 32'd3; bus.rs2_d = 32'd5; bus.rd_in = 4'd9;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.done) begin
        dones++;
        if (done_k1 < 0) begin done_k1 = k; r1 = bus.result; end
        else begin done_k2 = k; r2 = bus.result; end
      end
      if (!bus.busy && k <= 68) begin
        idle_cyc++;
        if (gap_k < 0) gap_k = k;
      end
      bus.rs1_d = 32'(k + 1);
      bus.rs2_d = 32'd2;
      if (k == 39) bus.start = 1'b0;
    end
    n_cmp++;
    if (dones !== 2) begin n_err++; $display("FAIL b2b_dones: got %0d want 2", dones); end
    n_cmp++;
    if (done_k1 !== 33 || r1 !== 32'd15) begin
      n_err++; $display("FAIL b2b_first: got k=%0d res=%h want k=33 res=0000000f", done_k1, r1);
    end
    n_cmp++;
    if (done_k2 !== 68 || r2 !== 32'd70) begin
      n_err++; $display("FAIL b2b_second: got k=%0d res=%h want k=68 res=00000046", done_k2, r2);
    end
    n_cmp++;
    if (idle_cyc !== 1 || gap_k !== 34) begin
      n_err++; $display("FAIL b2b_gap: got idle=%0d at k=%0d want idle=1 at k=34", idle_cyc, gap_k);
    end
  endtask

  task automatic test_reset_abort;
    int dones = 0;
    int lat; logic [31:0] res; logic [3:0] rdo; logic wen, after;
    @(negedge clk);
    bus.start = 1'b1; bus.op = 3'd4; bus.rs1_d = 32'd100; bus.rs2_d = 32'd7; bus.rd_in = 4'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (13) @(negedge clk);
    n_cmp++;
    if (bus.busy !== 1'b1) begin n_err++; $display("FAIL abort_busy_before: got %b want 1", bus.busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({bus.busy, bus.done} !== 2'b00 || bus.result !== 32'd0) begin
      n_err++; $display("FAIL abort_state: got busy/done=%b res=%h want 00 res=0", {bus.busy, bus.done}, bus.result);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    n_cmp++;
    if (dones !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d want 0", dones); end
    do_op(3'd3, 32'hFFFF_FFFF, 32'd2, 4'd7, lat, res, rdo, wen, after);
    n_cmp++;
    if (lat !== 34 || res !== 32'h0000_0001) begin
      n_err++; $display("FAIL abort_mulhu: got lat=%0d res=%h want lat=34 res=00000001", lat, res);
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_back_to_back();
    test_reset_abort();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
